// File: rtl/i2c_bus_arbiter_if.sv
// Shared-bus connection bundle between the I2C bus arbiter and its requesters.
interface i2c_bus_arbiter_if #(
  parameter int REQUESTER_COUNT = 4
);
  logic [REQUESTER_COUNT-1:0] request;
  logic [REQUESTER_COUNT-1:0] grant;
  logic [REQUESTER_COUNT-1:0] scl_output_in;
  logic [REQUESTER_COUNT-1:0] sda_output_in;
  logic                       scl_output;
  logic                       sda_output;
  logic                       busy;
  logic                       timeout;

  // Requester side.
  modport master (
    output request, scl_output_in, sda_output_in,
    input  grant, scl_output, sda_output, busy, timeout
  );

  // Arbiter side.
  modport slave (
    input  request, scl_output_in, sda_output_in,
    output grant, scl_output, sda_output, busy, timeout
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one open-drain I2C bus, with a bus-free gap between grants.
// Optional grant watchdog with per-requester lockout: define I2C_BUS_ARBITER_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int REQUESTER_COUNT = 4,
  parameter int GAP_CYCLES      = 500,
  parameter int TIMEOUT_CYCLES  = 10_000_000
) (
  input logic         clock,
  input logic         reset_n,
  i2c_bus_arbiter_if.slave bus
);

  localparam int unsigned RC = REQUESTER_COUNT;
  localparam int          PW = $clog2(REQUESTER_COUNT);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);
  localparam logic [RC-1:0] ONE = {{(RC-1){1'b0}}, 1'b1};

  if (REQUESTER_COUNT < 2 || REQUESTER_COUNT > 16) begin : g_bad_count
    $error("REQUESTER_COUNT out of range");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_gap
    $error("GAP_CYCLES out of range");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANTED, GAP} state_t;

  state_t          state;
  logic [RC-1:0]   grant_q;
  logic [PW-1:0]   pointer;
  logic [PW-1:0]   winner;
  logic [15:0]     gap_count;
  logic [RC-1:0]   eligible;
  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   pick_next;

`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0]   watchdog;
  logic [RC-1:0] lockout;
  logic          timeout_q;

  assign eligible = bus.request & ~lockout;
`else
  assign eligible = bus.request;
`endif

  // First eligible requester scanning upward from the pointer, wrapping at RC.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < RC; i++) begin
      idx = 32'(pointer) + i;
      if (idx >= RC) idx = idx - RC;
      if (!found && eligible[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    pick_next = (pick == PW'(RC - 1)) ? '0 : pick + PW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant_q   <= '0;
      pointer   <= '0;
      winner    <= '0;
      gap_count <= '0;
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
      watchdog  <= '0;
      lockout   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
      // A lockout bit survives only while its request stays high.
      lockout   <= lockout & bus.request;
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            grant_q <= ONE << pick;
            winner  <= pick;
            pointer <= pick_next;
            state   <= GRANTED;
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
            watchdog <= '0;
`endif
          end
        end
        GRANTED: begin
          if (!bus.request[winner]) begin
            grant_q   <= '0;
            gap_count <= GAP_LOAD;
            state     <= GAP;
          end
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
          else if (watchdog == WD_LIMIT) begin
            grant_q         <= '0;
            gap_count       <= GAP_LOAD;
            state           <= GAP;
            timeout_q       <= 1'b1;
            lockout[winner] <= 1'b1;
          end else begin
            watchdog <= watchdog + 32'd1;
          end
`endif
        end
        GAP: begin
          if (gap_count == '0) state <= IDLE;
          else                 gap_count <= gap_count - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // grant_q is one-hot or zero, so AND-ing released lines passes only the owner's drive.
  assign bus.grant      = grant_q;
  assign bus.scl_output = &(bus.scl_output_in | ~grant_q);
  assign bus.sda_output = &(bus.sda_output_in | ~grant_q);
  assign bus.busy       = (state != IDLE);
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter; covers the watchdog when I2C_BUS_ARBITER_TIMEOUT_EN is defined.
module tb_i2c_bus_arbiter;

  localparam int G = 10;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic ok;

  i2c_bus_arbiter_if #(.REQUESTER_COUNT(4)) bus ();

  i2c_bus_arbiter #(
    .REQUESTER_COUNT(4),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_grant;
    reset_n           = 1'b0;
    bus.request       = 4'b0000;
    bus.scl_output_in = 4'b1111;
    bus.sda_output_in = 4'b1111;
    repeat (2) @(posedge clock);
    #1;
    check("rst_grant",   32'(bus.grant),      32'h0);
    check("rst_busy",    32'(bus.busy),       32'h0);
    check("rst_scl",     32'(bus.scl_output), 32'h1);
    check("rst_sda",     32'(bus.sda_output), 32'h1);
    check("rst_timeout", 32'(bus.timeout),    32'h0);
    reset_n = 1'b1;
    tick();
    check("idle_grant", 32'(bus.grant), 32'h0);

    // Single requester
    bus.request = 4'b0100;
    tick();
    check("single_grant", 32'(bus.grant), 32'h4);
    check("single_busy",  32'(bus.busy),  32'h1);
    bus.scl_output_in = 4'b1011;
    #1;
    check("single_scl_low", 32'(bus.scl_output), 32'h0);
    check("single_sda_hi",  32'(bus.sda_output), 32'h1);
    bus.scl_output_in = 4'b1111;
    bus.sda_output_in = 4'b1011;
    #1;
    check("single_scl_hi",  32'(bus.scl_output), 32'h1);
    check("single_sda_low", 32'(bus.sda_output), 32'h0);
    bus.sda_output_in = 4'b1111;
    bus.request = 4'b0000;
    tick();
    check("single_drop_grant", 32'(bus.grant), 32'h0);
    check("single_drop_busy",  32'(bus.busy),  32'h1);
    ok = 1'b1;
    repeat (G - 1) begin
      tick();
      if (bus.busy !== 1'b1) ok = 1'b0;
    end
    check("single_gap_busy", 32'(ok), 32'h1);
    tick();
    check("single_gap_end", 32'(bus.busy), 32'h0);

    // Masking; pointer is now 3 so bit 0 wins by wrapping
    bus.request = 4'b0001;
    tick();
    check("mask_grant", 32'(bus.grant), 32'h1);
    bus.scl_output_in = 4'b0111;
    #1;
    check("mask_scl_ignore3", 32'(bus.scl_output), 32'h1);
    bus.scl_output_in = 4'b0110;
    #1;
    check("mask_scl_own0", 32'(bus.scl_output), 32'h0);
    bus.request = 4'b0000;
    tick();
    check("mask_drop_grant", 32'(bus.grant), 32'h0);
    bus.scl_output_in = 4'b0000;
    bus.sda_output_in = 4'b0000;
    #1;
    check("mask_nogrant_scl", 32'(bus.scl_output), 32'h1);
    check("mask_nogrant_sda", 32'(bus.sda_output), 32'h1);
    bus.scl_output_in = 4'b1111;
    bus.sda_output_in = 4'b1111;
    repeat (G) tick();
    check("mask_gap_end", 32'(bus.busy), 32'h0);

    // No pre-emption; pointer is 1
    bus.request = 4'b0010;
    tick();
    check("nopre_grant1", 32'(bus.grant), 32'h2);
    bus.request = 4'b0011;
    repeat (5) tick();
    check("nopre_held", 32'(bus.grant), 32'h2);
    bus.request = 4'b0001;
    tick();
    check("nopre_drop", 32'(bus.grant), 32'h0);
    repeat (G) tick();
    check("nopre_gap_grant", 32'(bus.grant), 32'h0);
    check("nopre_gap_busy",  32'(bus.busy),  32'h0);
    tick();
    check("nopre_grant0", 32'(bus.grant), 32'h1);
    bus.request = 4'b0000;
    tick();
    repeat (G) tick();

    // Reset mid-grant; pointer is 1
    bus.request = 4'b1000;
    tick();
    check("rstmid_grant", 32'(bus.grant), 32'h8);
    bus.sda_output_in = 4'b0111;
    #1;
    check("rstmid_sda_low", 32'(bus.sda_output), 32'h0);
    #1;
    reset_n = 1'b0;
    #1;
    check("rstmid_async_grant", 32'(bus.grant),      32'h0);
    check("rstmid_async_sda",   32'(bus.sda_output), 32'h1);
    check("rstmid_async_busy",  32'(bus.busy),       32'h0);
    bus.sda_output_in = 4'b1111;
    bus.request = 4'b1111;
    tick();
    tick();
    check("rstmid_held_grant", 32'(bus.grant), 32'h0);
    reset_n = 1'b1;
    tick();

    // Round robin from pointer 0 with all four requesting
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_grant = 4'b0001 << (k % 4);
      check("rr_grant", 32'(bus.grant), 32'(exp_grant));
      repeat (19) begin
        tick();
        if (bus.timeout !== 1'b0) ok = 1'b0;
      end
      check("rr_hold", 32'(bus.grant), 32'(exp_grant));
      bus.request = 4'b1111 & ~exp_grant;
      tick();
      check("rr_drop", 32'(bus.grant), 32'h0);
      bus.request = 4'b1111;
      repeat (G) tick();
      check("rr_gap", 32'(bus.grant), 32'h0);
      if (k < 4) tick();
    end
    check("rr_no_timeout", 32'(ok), 32'h1);
    bus.request = 4'b0000;
    tick();
    repeat (G) tick();

`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
    // Watchdog revoke and lockout; pointer is 1
    bus.request = 4'b0010;
    tick();
    check("to_grant", 32'(bus.grant), 32'h2);
    bus.request = 4'b0110;
    ok = 1'b1;
    repeat (99) begin
      tick();
      if (bus.grant !== 4'b0010 || bus.timeout !== 1'b0) ok = 1'b0;
    end
    check("to_before", 32'(ok), 32'h1);
    tick();
    check("to_revoke_grant", 32'(bus.grant),   32'h0);
    check("to_pulse",        32'(bus.timeout), 32'h1);
    tick();
    check("to_pulse_end", 32'(bus.timeout), 32'h0);
    repeat (G - 1) tick();
    check("to_gap", 32'(bus.grant), 32'h0);
    tick();
    check("to_grant2", 32'(bus.grant), 32'h4);
    bus.request = 4'b0010;
    tick();
    repeat (G) tick();
    repeat (5) tick();
    check("to_locked_grant", 32'(bus.grant), 32'h0);
    check("to_locked_busy",  32'(bus.busy),  32'h0);
    bus.request = 4'b0000;
    tick();
    bus.request = 4'b0010;
    tick();
    check("to_unlocked", 32'(bus.grant), 32'h2);
    bus.request = 4'b0000;
    tick();
    repeat (G) tick();
`else
    // No watchdog: a long grant is never revoked
    bus.request = 4'b0010;
    tick();
    check("long_grant", 32'(bus.grant), 32'h2);
    ok = 1'b1;
    repeat (150) begin
      tick();
      if (bus.grant !== 4'b0010 || bus.timeout !== 1'b0) ok = 1'b0;
    end
    check("long_held", 32'(ok), 32'h1);
    bus.request = 4'b0000;
    tick();
    check("long_drop", 32'(bus.grant), 32'h0);
    repeat (G) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one physical I2C bus (SCL/SDA open-drain pair) among REQUESTER_COUNT I2C masters, for example several device-configuration controllers each owning an I2CMaster.
- Each requester raises its request and waits for grant before driving the bus. The arbiter grants one requester at a time in round-robin order and forwards only that requester's SCL/SDA drive to the pads.
- It enforces a bus-free gap between consecutive grants.

Parameters:
- REQUESTER_COUNT, 4, number of requesters; legal range 2..16.
- GAP_CYCLES, 500, clock cycles the bus is held released (both lines 1) after a grant ends and before the next grant; legal range 1..65535.
- TIMEOUT_CYCLES, 10_000_000, maximum grant length in clock cycles. Used only when I2C_BUS_ARBITER_TIMEOUT_EN is defined.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- request  input  REQUESTER_COUNT  per-requester bus request; level, held high for the whole transaction.
- grant  output  REQUESTER_COUNT  per-requester grant; one-hot or zero; registered.
- scl_output_in  input  REQUESTER_COUNT  SCL drive from each requester (0 = pull low, 1 = release).
- sda_output_in  input  REQUESTER_COUNT  SDA drive from each requester.
- scl_output  output  1  SCL drive to the pad.
- sda_output  output  1  SDA drive to the pad.
- busy  output  1  high when any grant is active or a gap is running.
- timeout  output  1  single-cycle pulse when a grant is revoked by the watchdog. Tied 0 when the feature is compiled out.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, grant=0, pointer=0, gap counter=0, busy=0, timeout=0. scl_output and sda_output read 1.
- Pointer width is $clog2(REQUESTER_COUNT) and wraps modulo REQUESTER_COUNT.
- Bus muxing (combinational):
  - scl_output = scl_output_in[g] when grant[g]=1, else 1. sda_output uses the same rule.
  - Drive from requesters that are not granted is ignored.
- State IDLE:
  - If request is nonzero, choose the first set bit scanning upward from pointer, wrapping.
  - Register grant to that one-hot value and go to GRANTED. Latency from request to grant is 1 cycle.
  - Set pointer = winner+1 (wrapped).
- State GRANTED:
  - Grant is held while request[winner]=1.
  - Requests from other requesters are ignored until the grant ends. No pre-emption.
  - When request[winner]=0, clear grant on the next edge, load the gap counter with GAP_CYCLES-1, and go to GAP.
- State GAP:
  - grant=0 and the bus reads released.
  - The counter decrements each cycle. At 0, go to IDLE.
  - Requests arriving during GAP are evaluated in IDLE. The earliest grant is therefore GAP_CYCLES+1 cycles after the previous grant dropped.
- busy = (state != IDLE).
- Simultaneous requests are resolved strictly by the rotating pointer. No requester can be starved while others cycle.
- A requester that drops and re-raises request in the same cycle as its grant clears is treated as new and competes normally after GAP.
- REQUESTER_COUNT not a power of two: pointer increments skip to 0 past REQUESTER_COUNT-1.
- Asserting reset_n mid-transaction releases the bus immediately, because grant clears asynchronously.

Optional Feature:
- Macro: I2C_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on entry to GRANTED and increments each GRANTED cycle.
  - On reaching TIMEOUT_CYCLES-1, grant is cleared, timeout pulses for 1 cycle, and the state goes to GAP, even if request is still high.
  - The revoked requester must drop request to 0 before it is eligible again. A per-requester lockout bit is set on revoke and cleared when request goes low.
- Not defined:
  - No watchdog and no lockout logic.
  - The timeout port is tied 0 and a grant lasts indefinitely.

Test Plan:
- Single requester: request=4'b0100 from IDLE → grant=4'b0100 exactly 1 cycle later. Bus follows scl_output_in[2] and sda_output_in[2]. Drop request → grant=0 next cycle, then busy stays high for GAP_CYCLES cycles.
- Round robin: request=4'b1111 held, each winner drops after 20 cycles then re-raises → grant order 0,1,2,3,0. Each grant is separated by GAP_CYCLES+1 cycles.
- Masking: grant=4'b0001 while requester 3 drives scl_output_in[3]=0 → scl_output stays equal to scl_output_in[0]. With grant=0 and all inputs driving 0 → scl_output=1, sda_output=1.
- No pre-emption: grant to requester 1, then raise request[0] → grant stays 4'b0010 until request[1] falls. Requester 0 is granted after the gap.
- Reset mid-grant: grant=4'b1000 with SDA driven low, reset_n pulsed low between clock edges → grant=0 and sda_output=1 without waiting for a clock edge. After release the pointer is 0.
- Timeout (macro defined, TIMEOUT_CYCLES=100): request[1] held high → grant revoked at cycle 100 with a single timeout pulse. Requester 1 is not re-granted until request[1] drops and rises again. Requester 2, requesting meanwhile, is granted after the gap.
